// File: rtl/oled_pattern_sequencer_if.sv
// Frame hand-off bus between the pattern sequencer and the bitmap OLED interface.
// Latency: none (wires only).
// Backpressure: busy from the OLED side holds off update; bitmap stays stable while busy.
interface oled_pattern_sequencer_if #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 32
);
  logic                      update;
  logic [WIDTH*HEIGHT-1:0]   bitmap;
  logic                      busy;

  modport master (output update, output bitmap, input busy);
  modport slave  (input update, input bitmap, output busy);
endinterface

// File: rtl/oled_pattern_sequencer.sv
// Procedural test-pattern source for the bitmap OLED interface (button or dwell-timer selection).
// Latency: button level to pattern_index 1 cycle, to update/bitmap 2 cycles when not busy.
// Backpressure: changes while busy=1 coalesce into one pending update issued once busy drops.
module oled_pattern_sequencer #(
  parameter int WIDTH         = 128,
  parameter int HEIGHT        = 32,
  parameter int PATTERN_COUNT = 4,
  parameter int CELL_LOG2     = 3,
  parameter int DWELL_CYCLES  = 100_000_000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_mode,
  input  logic       invert,
  output logic [2:0] pattern_index,
  oled_pattern_sequencer_if.master oled
);

  localparam int             CNT_W    = $clog2(DWELL_CYCLES);
  localparam logic [2:0]     LAST_IDX = 3'(PATTERN_COUNT - 1);
  localparam logic [CNT_W-1:0] DWELL_TC = CNT_W'(DWELL_CYCLES - 1);
  localparam int             NPIX     = WIDTH * HEIGHT;

  logic             btn_next_q, btn_next_d;
  logic             btn_prev_q, btn_prev_d;
  logic             invert_q, invert_d;
  logic [2:0]       index_q, index_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             pending_q, pending_d;
  logic             update_q, update_d;
  logic [NPIX-1:0]  bitmap_q, bitmap_d;
  logic [NPIX-1:0]  frame;

  logic rise_next, rise_prev, dwell_tc, fire;

  // Single pixel of pattern pat at column x, row y (before inversion).
  function automatic logic pixel_at(input logic [2:0] pat, input int x, input int y);
    int   cx, cy, dg;
    logic px;
    cx = x >> CELL_LOG2;
    cy = y >> CELL_LOG2;
    dg = (x + y) >> CELL_LOG2;
    case (pat)
      3'd0:    px = cx[0] ^ cy[0];
      3'd1:    px = cy[0];
      3'd2:    px = cx[0];
      3'd3:    px = dg[0];
      3'd4:    px = (x == 0) || (x == WIDTH - 1) || (y == 0) || (y == HEIGHT - 1);
      3'd5:    px = 1'b1;
      3'd6:    px = 1'b0;
      default: px = ~(cx[0] ^ cy[0]);
    endcase
    return px;
  endfunction

  // Full frame for the registered index/invert; bit 0 is the bottom-right pixel.
  always_comb begin
    frame = '0;
    for (int y = 0; y < HEIGHT; y++) begin
      for (int x = 0; x < WIDTH; x++) begin
        frame[(HEIGHT - 1 - y) * WIDTH + (WIDTH - 1 - x)] = pixel_at(index_q, x, y) ^ invert_q;
      end
    end
  end

  // Selection, dwell timer and pending/update handshake.
  always_comb begin
    btn_next_d = btn_next;
    btn_prev_d = btn_prev;
    invert_d   = invert;
    index_d    = index_q;
    dwell_d    = dwell_q;
    pending_d  = pending_q;
    update_d   = 1'b0;
    bitmap_d   = bitmap_q;

    rise_next = btn_next & ~btn_next_q;
    rise_prev = btn_prev & ~btn_prev_q;
    dwell_tc  = auto_mode && (dwell_q == DWELL_TC);

    // Simultaneous next+prev cancel out and are not treated as an accepted edge.
    if (rise_next && !rise_prev) begin
      index_d = (index_q == LAST_IDX) ? 3'd0 : index_q + 3'd1;
    end else if (rise_prev && !rise_next) begin
      index_d = (index_q == 3'd0) ? LAST_IDX : index_q - 3'd1;
    end else if (dwell_tc) begin
      index_d = (index_q == LAST_IDX) ? 3'd0 : index_q + 3'd1;
    end

    if (!auto_mode || (rise_next ^ rise_prev) || dwell_tc) begin
      dwell_d = '0;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end

    // The update_q term keeps pulses at least one idle cycle apart.
    fire = pending_q && !oled.busy && !update_q;
    if (fire) begin
      update_d  = 1'b1;
      bitmap_d  = frame;
      pending_d = 1'b0;
    end
    if ((index_d != index_q) || (invert_d != invert_q)) begin
      pending_d = 1'b1;
    end
  end

  // State registers; reset leaves a pending request so the first frame goes out on release.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      btn_next_q <= 1'b0;
      btn_prev_q <= 1'b0;
      invert_q   <= 1'b0;
      index_q    <= 3'd0;
      dwell_q    <= '0;
      pending_q  <= 1'b1;
      update_q   <= 1'b0;
      bitmap_q   <= '0;
    end else begin
      btn_next_q <= btn_next_d;
      btn_prev_q <= btn_prev_d;
      invert_q   <= invert_d;
      index_q    <= index_d;
      dwell_q    <= dwell_d;
      pending_q  <= pending_d;
      update_q   <= update_d;
      bitmap_q   <= bitmap_d;
    end
  end

  assign oled.update   = update_q;
  assign oled.bitmap   = bitmap_q;
  assign pattern_index = index_q;

endmodule

// File: tb/tb_oled_pattern_sequencer.sv
// Directed bench for oled_pattern_sequencer: selection, wrap, coalescing, dwell, patterns.
// Latency: checks 1-cycle index and 2-cycle update timing.
// Backpressure: drives busy to verify update hold-off and bitmap stability.
module tb_oled_pattern_sequencer;

  logic clk = 1'b0;
  logic n_rst;
  logic btn_next, btn_prev, auto_mode, invert;
  logic b8_next, b8_prev;
  logic [2:0] idx, idx8;

  int n_vec = 0;
  int n_err = 0;
  int upd_cnt;
  logic [4:0] trace;
  logic [4095:0] bm0;

  always #5 clk = ~clk;

  oled_pattern_sequencer_if #(.WIDTH(128), .HEIGHT(32)) ifc ();
  oled_pattern_sequencer_if #(.WIDTH(128), .HEIGHT(32)) ifc8 ();

  oled_pattern_sequencer #(
    .WIDTH(128), .HEIGHT(32), .PATTERN_COUNT(4), .CELL_LOG2(3), .DWELL_CYCLES(10)
  ) dut (
    .clk(clk), .n_rst(n_rst), .btn_next(btn_next), .btn_prev(btn_prev),
    .auto_mode(auto_mode), .invert(invert), .pattern_index(idx), .oled(ifc.master)
  );

  oled_pattern_sequencer #(
    .WIDTH(128), .HEIGHT(32), .PATTERN_COUNT(8), .CELL_LOG2(3), .DWELL_CYCLES(10)
  ) dut8 (
    .clk(clk), .n_rst(n_rst), .btn_next(b8_next), .btn_prev(b8_prev),
    .auto_mode(1'b0), .invert(1'b0), .pattern_index(idx8), .oled(ifc8.master)
  );

  assign ifc8.busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling at each falling edge and counting update pulses.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ifc.update) upd_cnt++;
    end
  endtask

  task automatic press_next();
    btn_next = 1'b1; run(1); btn_next = 1'b0;
  endtask

  logic [2:0] exp_idx [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
  logic       exp_4087[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic       exp_3071[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    n_rst = 1'b0; btn_next = 0; btn_prev = 0; auto_mode = 0; invert = 0;
    b8_next = 0; b8_prev = 0; ifc.busy = 1'b0; upd_cnt = 0;
    run(2);
    chk("rst_update", 32'(ifc.update), 0);
    chk("rst_bitmap_any", 32'(|ifc.bitmap), 0);
    chk("rst_index", 32'(idx), 0);

    // Reset release: one update in cycle 1 with the checker pattern.
    n_rst = 1'b1;
    run(1);
    chk("post_rst_update", 32'(ifc.update), 1);
    chk("post_rst_bit4095", 32'(ifc.bitmap[4095]), 0);
    chk("post_rst_bit4087", 32'(ifc.bitmap[4087]), 1);
    chk("post_rst_index", 32'(idx), 0);
    run(4);
    chk("post_rst_upd_cnt", 32'(upd_cnt), 1);

    // Four next presses wrap 0->1->2->3->0, one update each.
    for (int i = 0; i < 4; i++) begin
      upd_cnt = 0;
      press_next();
      chk("next_index", 32'(idx), 32'(exp_idx[i]));
      run(3);
      chk("next_upd_cnt", 32'(upd_cnt), 1);
      chk("next_bit4087", 32'(ifc.bitmap[4087]), 32'(exp_4087[i]));
      chk("next_bit3071", 32'(ifc.bitmap[3071]), 32'(exp_3071[i]));
    end

    // Prev from 0 wraps to 3.
    upd_cnt = 0;
    btn_prev = 1'b1; run(1); btn_prev = 1'b0;
    chk("prev_wrap_index", 32'(idx), 3);
    run(3);
    chk("prev_upd_cnt", 32'(upd_cnt), 1);

    // Both rising together: no change, no update.
    upd_cnt = 0;
    btn_next = 1'b1; btn_prev = 1'b1; run(1); btn_next = 1'b0; btn_prev = 1'b0;
    run(4);
    chk("both_index", 32'(idx), 3);
    chk("both_upd_cnt", 32'(upd_cnt), 0);

    // Back to 0, then coalesce two nexts and an invert under busy.
    press_next(); run(4);
    chk("pre_busy_index", 32'(idx), 0);
    ifc.busy = 1'b1; run(1);
    bm0 = ifc.bitmap; upd_cnt = 0;
    press_next(); run(1); press_next(); run(1);
    invert = 1'b1; run(4);
    chk("busy_upd_cnt", 32'(upd_cnt), 0);
    chk("busy_bitmap_stable", 32'(ifc.bitmap == bm0), 1);
    chk("busy_index", 32'(idx), 2);
    ifc.busy = 1'b0; run(4);
    chk("coalesced_upd_cnt", 32'(upd_cnt), 1);
    chk("coalesced_bit4087", 32'(ifc.bitmap[4087]), 0);
    chk("coalesced_bit4095", 32'(ifc.bitmap[4095]), 1);

    // Change in the same cycle as an update pulse: second pulse follows after a gap.
    trace = '0;
    btn_next = 1'b1; run(1); trace[4] = ifc.update;
    btn_next = 1'b0; invert = 1'b0;
    run(1); trace[3] = ifc.update;
    run(1); trace[2] = ifc.update;
    run(1); trace[1] = ifc.update;
    run(1); trace[0] = ifc.update;
    chk("repend_trace", 32'(trace), 32'b01010);
    chk("repend_index", 32'(idx), 3);
    chk("repend_bit4087", 32'(ifc.bitmap[4087]), 1);
    chk("repend_bit4095", 32'(ifc.bitmap[4095]), 0);

    // Dwell timer with DWELL_CYCLES=10, restarted by a button press.
    auto_mode = 1'b1;
    run(9);
    chk("auto_before_tc", 32'(idx), 3);
    run(1);
    chk("auto_advance", 32'(idx), 0);
    run(5);
    press_next();
    chk("auto_btn_index", 32'(idx), 1);
    run(9);
    chk("auto_restart_hold", 32'(idx), 1);
    run(1);
    chk("auto_restart_adv", 32'(idx), 2);
    auto_mode = 1'b0;
    run(12);
    chk("auto_off_hold", 32'(idx), 2);

    // Eight-pattern instance: prev from 0 reaches 7 then 4 (frame).
    b8_prev = 1'b1; run(1); b8_prev = 1'b0; run(3);
    chk("p7_index", 32'(idx8), 7);
    chk("p7_bit4095", 32'(ifc8.bitmap[4095]), 1);
    chk("p7_bit4087", 32'(ifc8.bitmap[4087]), 0);
    for (int i = 0; i < 3; i++) begin
      b8_prev = 1'b1; run(1); b8_prev = 1'b0; run(1);
    end
    run(3);
    chk("p4_index", 32'(idx8), 4);
    chk("p4_bit0", 32'(ifc8.bitmap[0]), 1);
    chk("p4_bit127", 32'(ifc8.bitmap[127]), 1);
    chk("p4_bit128", 32'(ifc8.bitmap[128]), 1);
    chk("p4_bit129", 32'(ifc8.bitmap[129]), 0);
    chk("p4_bit3968", 32'(ifc8.bitmap[3968]), 1);
    chk("p4_bit4095", 32'(ifc8.bitmap[4095]), 1);
    chk("p4_bit2000", 32'(ifc8.bitmap[2000]), 0);

    // Mid-operation reset discards the pending request.
    ifc.busy = 1'b1;
    press_next(); run(1);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_index", 32'(idx), 0);
    chk("midrst_bitmap_any", 32'(|ifc.bitmap), 0);
    chk("midrst_update", 32'(ifc.update), 0);
    @(negedge clk);
    ifc.busy = 1'b0; upd_cnt = 0;
    n_rst = 1'b1;
    run(5);
    chk("midrst_upd_cnt", 32'(upd_cnt), 1);
    chk("midrst_bit4087", 32'(ifc.bitmap[4087]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
